// File: rtl/ws2812_pkg.sv
// Shared types and default 100 MHz timing for the WS2812 serializer.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_LATCH
    } state_e;

    localparam int DEF_T0H       = 40;
    localparam int DEF_T1H       = 80;
    localparam int DEF_TBIT      = 125;
    localparam int DEF_RESET_CYC = 5000;
    localparam int NBITS         = 24;

    function automatic int cnt_width(int a, int b);
        return $clog2(a > b ? a : b);
    endfunction

    // Wire order on the LED line is G, R, B, each MSB-first.
    function automatic logic [23:0] to_grb(logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_serializer_if.sv
// Pixel stream handshake between a colour producer and the serializer.
interface ws2812_serializer_if;

    logic [ws2812_pkg::NBITS-1:0] rgb_data_in;
    logic                         rgb_valid;
    logic                         rgb_last;
    logic                         rgb_ready;

    modport master (
        output rgb_data_in,
        output rgb_valid,
        output rgb_last,
        input  rgb_ready
    );

    modport slave (
        input  rgb_data_in,
        input  rgb_valid,
        input  rgb_last,
        output rgb_ready
    );

endinterface

// File: rtl/ws2812_bit_encoder.sv
// Per-bit timer: counts one bit period and decides the high/low phase.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT,
    parameter int CW   = cnt_width(DEF_TBIT, DEF_RESET_CYC)
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic bit_val,
    output logic dout_next,
    output logic bit_done
);

    localparam logic [CW-1:0] T0H_C  = CW'(T0H);
    localparam logic [CW-1:0] T1H_C  = CW'(T1H);
    localparam logic [CW-1:0] LAST_C = CW'(TBIT - 1);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] th;

    assign th        = bit_val ? T1H_C : T0H_C;
    assign bit_done  = run_q && (cnt_q == LAST_C);
    assign dout_next = run_q && (cnt_q < th);

    // A start on the terminal cycle chains the next bit with no gap.
    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
        end else if (bit_done) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ws2812_serializer.sv
// WS2812 single-wire serializer: one-entry hold buffer, GRB shifter,
// bit timer and latch gap, with led_dout registered.
module ws2812_serializer
    import ws2812_pkg::*;
#(
    parameter int T0H       = DEF_T0H,
    parameter int T1H       = DEF_T1H,
    parameter int TBIT      = DEF_TBIT,
    parameter int RESET_CYC = DEF_RESET_CYC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [23:0] rgb_data_in,
    input  logic        rgb_valid,
    input  logic        rgb_last,
    output logic        rgb_ready,
    output logic        led_dout,
    output logic        busy
);

    localparam int            CW       = cnt_width(TBIT, RESET_CYC);
    localparam logic [CW-1:0] LAT_LAST = CW'(RESET_CYC - 1);
    localparam logic [4:0]    BIT_LAST = 5'(NBITS - 1);

    logic [23:0]   hold_q, hold_d;
    logic          hold_last_q, hold_last_d;
    logic          hold_full_q, hold_full_d;

    state_e        state_q;
    logic [23:0]   sh_q;
    logic [4:0]    bitn_q;
    logic          cur_last_q;
    logic [CW-1:0] lcnt_q;
    logic          dout_q;

    logic          acc, take, start, last_bit;
    logic          dout_next, bit_done;

    assign rgb_ready = !hold_full_q;
    assign busy      = (state_q != ST_IDLE);
    assign led_dout  = dout_q;

    assign acc      = rgb_valid && !hold_full_q;
    assign last_bit = (bitn_q == BIT_LAST);
    assign take     = hold_full_q
                   && ((state_q == ST_IDLE)
                    || (state_q == ST_SEND && bit_done && last_bit));
    assign start    = take
                   || (state_q == ST_SEND && bit_done && !last_bit);

    ws2812_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT),
        .CW   (CW)
    ) u_enc (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .bit_val   (sh_q[23]),
        .dout_next (dout_next),
        .bit_done  (bit_done)
    );

    // acc needs an empty hold and take a full one, so they never collide.
    always_comb begin
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        if (take) begin
            hold_full_d = 1'b0;
        end else if (acc) begin
            hold_full_d = 1'b1;
            hold_d      = rgb_data_in;
            hold_last_d = rgb_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_LATCH;
            sh_q       <= '0;
            bitn_q     <= '0;
            cur_last_q <= 1'b0;
            lcnt_q     <= '0;
            dout_q     <= 1'b0;
        end else begin
            dout_q <= (state_q == ST_SEND) && dout_next;
            unique case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        sh_q       <= to_grb(hold_q);
                        cur_last_q <= hold_last_q;
                        bitn_q     <= '0;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bit_done) begin
                        if (!last_bit) begin
                            sh_q   <= {sh_q[22:0], 1'b0};
                            bitn_q <= bitn_q + 5'd1;
                        end else if (take) begin
                            sh_q       <= to_grb(hold_q);
                            cur_last_q <= hold_last_q;
                            bitn_q     <= '0;
                        end else if (cur_last_q) begin
                            bitn_q  <= '0;
                            lcnt_q  <= '0;
                            state_q <= ST_LATCH;
                        end else begin
                            bitn_q  <= '0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_LATCH: begin
                    if (lcnt_q == LAT_LAST) begin
                        lcnt_q  <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        lcnt_q <= lcnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_LATCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Scoreboard bench: the driver queues expected bits, a monitor decodes led_dout.
module tb_ws2812_serializer;

    localparam int T0H  = 2;
    localparam int T1H  = 4;
    localparam int TBIT = 6;
    localparam int RC   = 20;

    typedef struct {
        logic v;
        logic contig;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic led;
    logic busy;

    exp_t sb[$];
    int   errs   = 0;
    int   checks = 0;

    logic m_prev = 1'b0;
    int   m_hi   = 0;
    int   m_lo   = 0;
    exp_t m_e;

    ws2812_serializer_if bus ();

    always #5 clk = ~clk;

    ws2812_serializer #(
        .T0H       (T0H),
        .T1H       (T1H),
        .TBIT      (TBIT),
        .RESET_CYC (RC)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rgb_data_in (bus.rgb_data_in),
        .rgb_valid   (bus.rgb_valid),
        .rgb_last    (bus.rgb_last),
        .rgb_ready   (bus.rgb_ready),
        .led_dout    (led),
        .busy        (busy)
    );

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pixel(logic [23:0] d, logic contig);
        logic [23:0] g;
        exp_t        e;
        g = {d[15:8], d[23:16], d[7:0]};
        for (int i = 0; i < 24; i++) begin
            e.v      = g[23-i];
            e.contig = (i > 0) || contig;
            sb.push_back(e);
        end
    endtask

    task automatic send(logic [23:0] d, logic last, logic contig);
        logic got;
        logic r;
        got = 1'b0;
        bus.rgb_valid   = 1'b1;
        bus.rgb_data_in = d;
        bus.rgb_last    = last;
        for (int n = 0; n < 400 && !got; n++) begin
            r = bus.rgb_ready;
            tick();
            if (r) got = 1'b1;
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
        end else begin
            push_pixel(d, contig);
            chk("ready_drop", int'(bus.rgb_ready), 0);
        end
    endtask

    task automatic go_idle();
        bus.rgb_valid   = 1'b0;
        bus.rgb_data_in = 24'($urandom);
        bus.rgb_last    = 1'b1;
    endtask

    task automatic rise_latency(output int n);
        n = 0;
        while (!led && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(output int lowrun);
        int n;
        lowrun = 0;
        n      = 0;
        for (int k = 0; k < 10 && !busy; k++) tick();
        while (busy && n < 600) begin
            if (led) lowrun = 0;
            else     lowrun++;
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", 0, 1);
    endtask

    function automatic int tail_low(logic lastbit);
        return TBIT - (lastbit ? T1H : T0H) - 1;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_prev = 1'b0;
                m_hi   = 0;
                m_lo   = 0;
            end else begin
                if (led && !m_prev) begin
                    if (sb.size() == 0)
                        chk("spurious_bit", 1, 0);
                    else if (sb[0].contig)
                        chk("bit_period", m_hi + m_lo, TBIT);
                    m_hi = 1;
                end else if (led) begin
                    m_hi++;
                end else if (m_prev) begin
                    if (sb.size() == 0) begin
                        chk("extra_bit", 1, 0);
                    end else begin
                        m_e = sb.pop_front();
                        chk("bit_high", m_hi, m_e.v ? T1H : T0H);
                    end
                    m_lo = 1;
                end else begin
                    m_lo++;
                end
                m_prev = led;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          n, hi_cnt, lr, rises;
        logic        p;
        logic [23:0] px [10];

        bus.rgb_valid   = 1'b0;
        bus.rgb_data_in = '0;
        bus.rgb_last    = 1'b0;
        resetn          = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;

        // Power-up latch gap.
        n      = 0;
        hi_cnt = 0;
        while (busy && n < 100) begin
            if (led) hi_cnt++;
            n++;
            tick();
        end
        chk("reset_latch_len", n, RC);
        chk("reset_led_low", hi_cnt, 0);
        chk("ready_after_reset", int'(bus.rgb_ready), 1);

        // Single framed pixel.
        send(24'hFF0000, 1'b1, 1'b0);
        go_idle();
        rise_latency(n);
        chk("first_rise", n, 2);
        wait_idle(lr);
        chk("latch_low", lr, tail_low(1'b0) + RC);
        chk("sb_drain_1", sb.size(), 0);

        // Three pixels back-to-back.
        send(24'h00FF00, 1'b0, 1'b0);
        send(24'h0000FF, 1'b0, 1'b1);
        send(24'hAAAAAA, 1'b1, 1'b1);
        go_idle();
        wait_idle(lr);
        chk("stream_latch_low", lr, tail_low(1'b0) + RC);
        chk("sb_drain_2", sb.size(), 0);

        // Underrun without last: straight to IDLE, no latch.
        send(24'h123456, 1'b0, 1'b0);
        go_idle();
        rise_latency(n);
        chk("underrun_first_rise", n, 2);
        wait_idle(lr);
        chk("underrun_low", lr, tail_low(1'b0));
        chk("underrun_led", int'(led), 0);
        repeat (3) tick();
        send(24'h808080, 1'b1, 1'b0);
        go_idle();
        rise_latency(n);
        chk("after_underrun_rise", n, 2);
        wait_idle(lr);
        chk("after_underrun_latch", lr, tail_low(1'b0) + RC);

        // Reset during bit 10.
        send(24'hFFFFFF, 1'b1, 1'b0);
        go_idle();
        rises = 0;
        p     = led;
        for (int k = 0; k < 500 && rises < 11; k++) begin
            tick();
            if (led && !p) rises++;
            p = led;
        end
        chk("bit10_reached", rises, 11);
        resetn = 1'b0;
        sb.delete();
        tick();
        chk("reset_kill", int'(led), 0);
        chk("reset_busy", int'(busy), 1);
        chk("reset_ready", int'(bus.rgb_ready), 1);
        tick();
        resetn = 1'b1;
        send(24'h0F0F0F, 1'b1, 1'b0);
        go_idle();
        rise_latency(n);
        chk("post_reset_gap", n + 1, RC + 2);
        wait_idle(lr);
        chk("post_reset_latch", lr, tail_low(1'b1) + RC);
        chk("sb_drain_3", sb.size(), 0);

        // Valid held high across ten pixels.
        for (int k = 0; k < 10; k++) px[k] = 24'($urandom);
        for (int k = 0; k < 10; k++)
            send(px[k], k == 9, k > 0);
        go_idle();
        wait_idle(lr);
        chk("burst_latch_low", lr, tail_low(px[9][0]) + RC);
        chk("sb_drain_4", sb.size(), 0);

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
